// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and helpers for the BCD seconds stopwatch.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package stopwatch_counter_pkg;

  // Largest value a decimal digit may hold before rolling over.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Simulation-scaled tick rate; the board top overrides it.
  localparam int DEFAULT_CLK_FREQ = 10_000_000;

  // Prescaler width for a given cycles-per-second count (at least 1 bit).
  function automatic int presc_width(input int clk_freq);
    return (clk_freq < 2) ? 1 : $clog2(clk_freq);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bus between the stopwatch controller and the counter.
// Latency: n/a (wires only).
// Backpressure: none; time_reading is a continuously valid level.
interface stopwatch_counter_if;

  logic       count_enabled;
  logic [7:0] time_reading;

  // Controller side: owns run/pause, observes the reading.
  modport master (output count_enabled, input time_reading);
  // Counter side: obeys run/pause, drives the reading.
  modport slave  (input count_enabled, output time_reading);

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single decimal digit counter (0..9) with carry-out for chaining.
// Latency: digit updates on the edge where inc is high; carry is combinational.
// Backpressure: none; every inc pulse is consumed.
module bcd_digit
  import stopwatch_counter_pkg::*;
(
  input  logic       clk,
  input  logic       init_regs,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  // Carry fires on the increment that rolls this digit from 9 back to 0.
  assign carry = inc && (digit == BCD_MAX);

  // Advance on inc; anything at or above 9 rolls to 0 so A..F can never appear.
  always_ff @(posedge clk or posedge init_regs) begin
    if (init_regs) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Two-digit BCD seconds counter (00..99, wrapping) driven by a clock prescaler.
// Latency: digits change on the same edge the prescaler wraps; output is registered.
// Backpressure: none; count_enabled low freezes prescaler and digits in place.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic                clk,
  input  logic                init_regs,
  stopwatch_counter_if.slave  bus
);

  localparam int              PW         = presc_width(CLK_FREQ);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic          ones_carry;
  logic          unused_tens_carry;

  // A second elapses only on an enabled edge at the last prescaler count,
  // so pausing on the wrapping edge keeps the prescaler parked at the end.
  assign tick = bus.count_enabled && (presc == PRESC_LAST);

  // Prescaler: counts enabled cycles, holds while paused, wraps once per second.
  always_ff @(posedge clk or posedge init_regs) begin
    if (init_regs) begin
      presc <= '0;
    end else if (bus.count_enabled) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  bcd_digit u_ones (
    .clk       (clk),
    .init_regs (init_regs),
    .inc       (tick),
    .digit     (ones),
    .carry     (ones_carry)
  );

  // Tens carry is dropped: that is what makes 99 roll over to 00.
  bcd_digit u_tens (
    .clk       (clk),
    .init_regs (init_regs),
    .inc       (ones_carry),
    .digit     (tens),
    .carry     (unused_tens_carry)
  );

  assign bus.time_reading = {tens, ones};

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with a small CLK_FREQ.
// Latency: expected reading queued one step after each edge / async clear.
// Backpressure: n/a.
module tb_stopwatch_counter;

  localparam int CF = 4;

  logic clk;
  logic init_regs;

  stopwatch_counter_if bus ();

  stopwatch_counter #(.CLK_FREQ(CF)) dut (
    .clk       (clk),
    .init_regs (init_regs),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: number of enabled, non-reset edges since the last reset.
  int         n_en;
  logic [7:0] exp_q[$];
  int         vectors;
  int         miscompares;
  event       async_ev;

  function automatic logic [7:0] expected_reading(input int n);
    int secs;
    secs = (n / CF) % 100;
    return {4'(secs / 10), 4'(secs % 10)};
  endfunction

  // Monitor: compare the reading on every falling edge and after async clears.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk or async_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.time_reading !== e) begin
          miscompares++;
          $display("FAIL time_reading: got %h expected %h at %0t", bus.time_reading, e, $time);
        end
      end
    end
  end

  // One clock edge with the given enable; model updated from what the edge saw.
  task automatic step(input logic en);
    bus.count_enabled = en;
    @(posedge clk);
    #1;
    if (!init_regs && en) n_en++;
    exp_q.push_back(expected_reading(n_en));
  endtask

  // Assert reset between edges and check the output clears before any edge.
  task automatic async_reset();
    @(negedge clk);
    #1;
    init_regs = 1'b1;
    n_en = 0;
    #1;
    exp_q.push_back(expected_reading(n_en));
    -> async_ev;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_en        = 0;
    init_regs   = 1'b1;
    bus.count_enabled = 1'b0;

    // Reset state, checked before any clock edge.
    #2;
    exp_q.push_back(expected_reading(0));
    -> async_ev;
    #1;

    // Reset held with enable high: stays at 00.
    for (int i = 0; i < 20; i++) step(1'b1);
    init_regs = 1'b0;

    // Long run: 00..99, wrap to 00 at 400 edges, then a few more seconds.
    for (int i = 0; i < 420; i++) step(1'b1);

    // Pause keeps the partial second.
    async_reset();
    init_regs = 1'b0;
    for (int i = 0; i < 2; i++)  step(1'b1);
    for (int i = 0; i < 50; i++) step(1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1);

    // Enable dropping exactly on the wrapping edge.
    for (int i = 0; i < 2; i++)  step(1'b1);
    for (int i = 0; i < 5; i++)  step(1'b0);
    for (int i = 0; i < 2; i++)  step(1'b1);

    // Reset mid-operation at 37 loses the partial second.
    async_reset();
    init_regs = 1'b0;
    for (int i = 0; i < 37 * CF + 2; i++) step(1'b1);
    async_reset();
    step(1'b1);
    init_regs = 1'b0;
    for (int i = 0; i < CF + 1; i++) step(1'b1);

    // Random enables with occasional asynchronous clears.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(1'($urandom_range(0, 1)));
        init_regs = 1'b0;
      end else begin
        step($urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
